pcie_htile_rx_bridge: RTL and testbench

Adapts the H-tile PCIe hard-IP Avalon-ST RX interface, which has a fixed ready latency, to the FIM's AXI4-Stream PCIe RX interface. Each beat carries NUM_CH TLP channels. Beats are absorbed into a small show-ahead FIFO, so the Avalon source's in-flight beats after ready deasserts are never lost. The block sits between the PCIe IP RX port and the FIM RX arbitration/demux logic; a P-tile variant shares this interface.

---
 rtl/pcie_htile_rx_bridge.sv | 143 ++++++++++++++
 tb/tb_pcie_htile_rx_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_htile_rx_bridge.sv
// pcie_htile_rx_bridge
// Converts the H-tile Avalon-ST RX stream, which has a fixed ready latency,
// into the FIM AXI4-Stream RX format. Each beat carries NUM_CH TLP channels.
// Beats go into a show-ahead FIFO. Ready deasserts early enough that every
// beat the source still has in flight fits in the remaining slots.
// FIFO_DEPTH must be at least READY_LATENCY+2.
module pcie_htile_rx_bridge #(
  parameter int NUM_CH        = 2,
  parameter int HDR_W         = 128,
  parameter int DATA_W        = 256,
  parameter int READY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     avl_clk,
  input  logic                     avl_rst,
  input  logic [NUM_CH-1:0]        avl_rx_valid,
  input  logic [NUM_CH-1:0]        avl_rx_sop,
  input  logic [NUM_CH-1:0]        avl_rx_eop,
  input  logic [NUM_CH*HDR_W-1:0]  avl_rx_hdr,
  input  logic [NUM_CH*DATA_W-1:0] avl_rx_data,
  input  logic [NUM_CH*3-1:0]      avl_rx_bar,
  output logic                     avl_rx_ready,
  output logic                     axis_rx_tvalid,
  input  logic                     axis_rx_tready,
  output logic [NUM_CH-1:0]        axis_rx_valid,
  output logic [NUM_CH-1:0]        axis_rx_sop,
  output logic [NUM_CH-1:0]        axis_rx_eop,
  output logic [NUM_CH*HDR_W-1:0]  axis_rx_hdr,
  output logic [NUM_CH*DATA_W-1:0] axis_rx_payload,
  output logic [NUM_CH*3-1:0]      axis_rx_bar,
  output logic                     err_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - READY_LATENCY - 1);

  // Entry storage. Data slots carry no reset; the occupancy count decides validity.
  logic [NUM_CH-1:0]        r_mem_vld  [FIFO_DEPTH];
  logic [NUM_CH-1:0]        r_mem_sop  [FIFO_DEPTH];
  logic [NUM_CH-1:0]        r_mem_eop  [FIFO_DEPTH];
  logic [NUM_CH*HDR_W-1:0]  r_mem_hdr  [FIFO_DEPTH];
  logic [NUM_CH*DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [NUM_CH*3-1:0]      r_mem_bar  [FIFO_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [NUM_CH-1:0]        w_wr_sop;
  logic [NUM_CH-1:0]        w_wr_eop;
  logic [NUM_CH*HDR_W-1:0]  w_wr_hdr;
  logic [NUM_CH*DATA_W-1:0] w_wr_data;
  logic [NUM_CH*3-1:0]      w_wr_bar;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_wr_en;
  logic                     w_ovf;

  // The wrap is explicit because the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign w_push  = |avl_rx_valid;
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = (r_count != '0) && axis_rx_tready;
  // At full, a concurrent pop frees the slot that this write reuses.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  // Zero every field of an invalid channel so stale lanes never reach the sink.
  always_comb begin
    w_wr_sop  = avl_rx_sop & avl_rx_valid;
    w_wr_eop  = avl_rx_eop & avl_rx_valid;
    w_wr_hdr  = '0;
    w_wr_data = '0;
    w_wr_bar  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (avl_rx_valid[ch]) begin
        w_wr_hdr[ch*HDR_W +: HDR_W]    = avl_rx_hdr[ch*HDR_W +: HDR_W];
        w_wr_data[ch*DATA_W +: DATA_W] = avl_rx_data[ch*DATA_W +: DATA_W];
        w_wr_bar[ch*3 +: 3]            = avl_rx_bar[ch*3 +: 3];
      end
    end
  end

  // ---- write stage: capture masked beat into the slot at the write pointer ----
  // Write the accepted beat into storage.
  always_ff @(posedge avl_clk) begin
    if (w_wr_en) begin
      r_mem_vld[r_wr_ptr]  <= avl_rx_valid;
      r_mem_sop[r_wr_ptr]  <= w_wr_sop;
      r_mem_eop[r_wr_ptr]  <= w_wr_eop;
      r_mem_hdr[r_wr_ptr]  <= w_wr_hdr;
      r_mem_data[r_wr_ptr] <= w_wr_data;
      r_mem_bar[r_wr_ptr]  <= w_wr_bar;
    end
  end

  // Update pointers, occupancy and the sticky overflow flag. Reset flushes the queue.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wr_en && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_en && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---- read stage: show-ahead head slot drives the AXI-S outputs ----
  assign avl_rx_ready    = !avl_rst && (r_count <= READY_MAX);
  assign axis_rx_tvalid  = (r_count != '0);
  assign axis_rx_valid   = r_mem_vld[r_rd_ptr];
  assign axis_rx_sop     = r_mem_sop[r_rd_ptr];
  assign axis_rx_eop     = r_mem_eop[r_rd_ptr];
  assign axis_rx_hdr     = r_mem_hdr[r_rd_ptr];
  assign axis_rx_payload = r_mem_data[r_rd_ptr];
  assign axis_rx_bar     = r_mem_bar[r_rd_ptr];
  assign err_overflow    = r_err;

endmodule

// File: tb/tb_pcie_htile_rx_bridge.sv
// Testbench for pcie_htile_rx_bridge: directed vector table plus a
// hand-written check of the latency after a reset.
module tb_pcie_htile_rx_bridge;

  localparam int NUM_CH = 2;
  localparam int HDR_W  = 128;
  localparam int DATA_W = 256;

  logic                     avl_clk;
  logic                     avl_rst;
  logic [NUM_CH-1:0]        avl_rx_valid;
  logic [NUM_CH-1:0]        avl_rx_sop;
  logic [NUM_CH-1:0]        avl_rx_eop;
  logic [NUM_CH*HDR_W-1:0]  avl_rx_hdr;
  logic [NUM_CH*DATA_W-1:0] avl_rx_data;
  logic [NUM_CH*3-1:0]      avl_rx_bar;
  logic                     avl_rx_ready;
  logic                     axis_rx_tvalid;
  logic                     axis_rx_tready;
  logic [NUM_CH-1:0]        axis_rx_valid;
  logic [NUM_CH-1:0]        axis_rx_sop;
  logic [NUM_CH-1:0]        axis_rx_eop;
  logic [NUM_CH*HDR_W-1:0]  axis_rx_hdr;
  logic [NUM_CH*DATA_W-1:0] axis_rx_payload;
  logic [NUM_CH*3-1:0]      axis_rx_bar;
  logic                     err_overflow;

  pcie_htile_rx_bridge #(
    .NUM_CH(NUM_CH), .HDR_W(HDR_W), .DATA_W(DATA_W),
    .READY_LATENCY(3), .FIFO_DEPTH(8)
  ) dut (
    .avl_clk(avl_clk), .avl_rst(avl_rst),
    .avl_rx_valid(avl_rx_valid), .avl_rx_sop(avl_rx_sop), .avl_rx_eop(avl_rx_eop),
    .avl_rx_hdr(avl_rx_hdr), .avl_rx_data(avl_rx_data), .avl_rx_bar(avl_rx_bar),
    .avl_rx_ready(avl_rx_ready),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_valid(axis_rx_valid), .axis_rx_sop(axis_rx_sop), .axis_rx_eop(axis_rx_eop),
    .axis_rx_hdr(axis_rx_hdr), .axis_rx_payload(axis_rx_payload), .axis_rx_bar(axis_rx_bar),
    .err_overflow(err_overflow)
  );

  initial avl_clk = 1'b0;
  always #5 avl_clk = ~avl_clk;

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [7:0] tag;
    logic       trdy;
    logic       e_tv;
    logic       e_rdy;
    logic       e_err;
    logic [1:0] e_vld;
    logic [7:0] e_tag;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_pass;

  // Per-channel field patterns derived from a beat tag.
  function automatic logic [HDR_W-1:0] hdr_of(input logic [7:0] t, input int ch);
    return {8{8'h4A ^ 8'(ch), t}};
  endfunction
  function automatic logic [DATA_W-1:0] data_of(input logic [7:0] t, input int ch);
    return {16{8'(ch + 16), t}};
  endfunction
  function automatic logic [2:0] bar_of(input logic [7:0] t, input int ch);
    return t[2:0] ^ 3'(ch + 1);
  endfunction

  task automatic add(input logic r, input logic [1:0] v, input logic [7:0] t, input logic q,
                     input logic tv, input logic rdy, input logic er,
                     input logic [1:0] ev, input logic [7:0] et);
    vec_t x;
    x.rst = r; x.vld = v; x.tag = t; x.trdy = q;
    x.e_tv = tv; x.e_rdy = rdy; x.e_err = er; x.e_vld = ev; x.e_tag = et;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Raw fields are driven on every channel, valid or not.
  task automatic drive(input logic r, input logic [1:0] v, input logic [7:0] t, input logic q);
    avl_rst        = r;
    avl_rx_valid   = v;
    axis_rx_tready = q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      avl_rx_sop[ch]                   = 1'b1;
      avl_rx_eop[ch]                   = t[ch];
      avl_rx_hdr[ch*HDR_W +: HDR_W]    = hdr_of(t, ch);
      avl_rx_data[ch*DATA_W +: DATA_W] = data_of(t, ch);
      avl_rx_bar[ch*3 +: 3]            = bar_of(t, ch);
    end
  endtask

  task automatic check_out(input string p, input logic tv, input logic rdy, input logic er,
                           input logic [1:0] ev, input logic [7:0] et);
    chk({p, ".tvalid"}, DATA_W'(axis_rx_tvalid), DATA_W'(tv));
    chk({p, ".ready"},  DATA_W'(avl_rx_ready),   DATA_W'(rdy));
    chk({p, ".err"},    DATA_W'(err_overflow),   DATA_W'(er));
    if (tv) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        chk($sformatf("%s.ch%0d.valid", p, ch), DATA_W'(axis_rx_valid[ch]), DATA_W'(ev[ch]));
        chk($sformatf("%s.ch%0d.sop", p, ch), DATA_W'(axis_rx_sop[ch]), DATA_W'(ev[ch]));
        chk($sformatf("%s.ch%0d.eop", p, ch), DATA_W'(axis_rx_eop[ch]), DATA_W'(ev[ch] & et[ch]));
        chk($sformatf("%s.ch%0d.hdr", p, ch), DATA_W'(axis_rx_hdr[ch*HDR_W +: HDR_W]),
            ev[ch] ? DATA_W'(hdr_of(et, ch)) : '0);
        chk($sformatf("%s.ch%0d.payload", p, ch), axis_rx_payload[ch*DATA_W +: DATA_W],
            ev[ch] ? data_of(et, ch) : '0);
        chk($sformatf("%s.ch%0d.bar", p, ch), DATA_W'(axis_rx_bar[ch*3 +: 3]),
            ev[ch] ? DATA_W'(bar_of(et, ch)) : '0);
      end
    end
  endtask

  initial begin
    int lat;
    n_chk  = 0;
    n_pass = 0;

    // Reset, then idle.
    add(1, 2'b00, 8'h00, 0,  0, 0, 0, 2'b00, 8'h00);
    add(0, 2'b00, 8'h00, 0,  0, 1, 0, 2'b00, 8'h00);
    add(0, 2'b00, 8'h00, 1,  0, 1, 0, 2'b00, 8'h00);
    // A single beat on ch0 appears one cycle later and drains.
    add(0, 2'b01, 8'h01, 1,  1, 1, 0, 2'b01, 8'h01);
    add(0, 2'b00, 8'h00, 1,  0, 1, 0, 2'b00, 8'h00);
    // Backpressure: 8 beats, ready drops at count 5, 3 in-flight beats still land.
    for (int t = 1; t <= 8; t++) add(0, 2'b11, 8'(t), 0,  1, t <= 4, 0, 2'b11, 8'h01);
    add(0, 2'b00, 8'h00, 0,  1, 0, 0, 2'b11, 8'h01);
    for (int k = 1; k <= 8; k++)
      add(0, 2'b00, 8'h00, 1,  k < 8, (8 - k) <= 4, 0, (k < 8) ? 2'b11 : 2'b00,
          (k < 8) ? 8'(k + 1) : 8'h00);
    // Empty beats between valid ones are discarded; ch0 masked in the first beat.
    add(0, 2'b10, 8'h21, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b00, 8'h99, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b00, 8'h98, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b00, 8'h97, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b00, 8'h96, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b01, 8'h22, 0,  1, 1, 0, 2'b10, 8'h21);
    add(0, 2'b00, 8'h00, 1,  1, 1, 0, 2'b01, 8'h22);
    add(0, 2'b00, 8'h00, 1,  0, 1, 0, 2'b00, 8'h00);
    // Fill to 8, push+pop at full, then overflow at full.
    for (int t = 1; t <= 8; t++) add(0, 2'b11, 8'(48 + t), 0,  1, t <= 4, 0, 2'b11, 8'h31);
    add(0, 2'b11, 8'h39, 1,  1, 0, 0, 2'b11, 8'h32);
    add(0, 2'b11, 8'h3A, 0,  1, 0, 1, 2'b11, 8'h32);
    add(0, 2'b00, 8'h00, 0,  1, 0, 1, 2'b11, 8'h32);
    for (int k = 1; k <= 8; k++)
      add(0, 2'b00, 8'h00, 1,  k < 8, (8 - k) <= 4, 1, (k < 8) ? 2'b11 : 2'b00,
          (k < 8) ? 8'(50 + k) : 8'h00);
    // Reset with 5 beats queued, while a push is presented.
    for (int t = 1; t <= 5; t++) add(0, 2'b11, 8'(64 + t), 0,  1, t <= 4, 1, 2'b11, 8'h41);
    add(1, 2'b11, 8'h46, 0,  0, 0, 0, 2'b00, 8'h00);
    add(0, 2'b00, 8'h00, 0,  0, 1, 0, 2'b00, 8'h00);
    add(0, 2'b01, 8'h51, 0,  1, 1, 0, 2'b01, 8'h51);
    add(0, 2'b00, 8'h00, 1,  0, 1, 0, 2'b00, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].tag, vecs[i].trdy);
      @(posedge avl_clk);
      #1;
      check_out($sformatf("r%0d", i), vecs[i].e_tv, vecs[i].e_rdy, vecs[i].e_err,
                vecs[i].e_vld, vecs[i].e_tag);
    end

    // Hand-written: reset again, then measure the push-to-tvalid latency with a bounded wait.
    drive(1, 2'b00, 8'h00, 0);
    @(posedge avl_clk);
    #1;
    drive(0, 2'b11, 8'h61, 0);
    lat = 0;
    @(posedge avl_clk);
    #1;
    lat++;
    drive(0, 2'b00, 8'h00, 0);
    while (!axis_rx_tvalid && lat < 10) begin
      @(posedge avl_clk);
      #1;
      lat++;
    end
    chk("hs.latency", DATA_W'(lat), DATA_W'(1));
    check_out("hs.head", 1, 1, 0, 2'b11, 8'h61);
    axis_rx_tready = 1'b1;
    @(posedge avl_clk);
    #1;
    check_out("hs.drain", 0, 1, 0, 2'b00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
